// File: rtl/qpad_if.sv
// Valid/ready queue channel. master drives valid and data (producer side),
// slave returns ready (consumer side); for data queues the MSB of data is eot.
interface qpad_if #(
   parameter int W = 17
);
   logic         valid;
   logic         ready;
   logic [W-1:0] data;

   modport master (output valid, output data, input ready);
   modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/qpad.sv
// Transaction padder: forwards an eot-terminated transaction and appends PAD_VAL
// beats until the output reaches the configured length; longer inputs pass untouched.
module qpad #(
   parameter int                W_DATA  = 16,
   parameter int                W_CFG   = 16,
   parameter logic [W_DATA-1:0] PAD_VAL = {W_DATA{1'b0}}
) (
   input  logic   clk,
   input  logic   rst,
   qpad_if.slave  cfg,
   qpad_if.slave  din,
   qpad_if.master dout
);

   typedef enum logic [0:0] {
      PASS = 1'b0,
      PAD  = 1'b1
   } mode_t;

   mode_t              mode_q;
   mode_t              mode_d;
   logic [W_CFG-1:0]   cnt_q;
   logic [W_CFG-1:0]   cnt_d;
   logic [W_CFG:0]     cnt_next_s;
   logic [W_CFG:0]     cfg_len_s;
   logic               reach_s;
   logic               exact_s;
   logic               din_eot_s;
   logic               dout_valid_s;
   logic               dout_eot_s;
   logic [W_DATA-1:0]  dout_payload_s;
   logic               din_ready_s;
   logic               cfg_ready_s;
   logic               hs_s;

   // Length compare runs one bit wider than cnt so a saturated count never wraps.
   always_comb begin
      cnt_next_s = {1'b0, cnt_q} + {{W_CFG{1'b0}}, 1'b1};
      cfg_len_s  = {1'b0, cfg.data[W_CFG-1:0]};
      reach_s    = (cnt_next_s >= cfg_len_s);
      exact_s    = (cnt_next_s == cfg_len_s);
      din_eot_s  = din.data[W_DATA];
   end

   // Output handshake steering and next-state selection.
   always_comb begin
      mode_d         = mode_q;
      cnt_d          = cnt_q;
      dout_valid_s   = 1'b0;
      dout_eot_s     = 1'b0;
      dout_payload_s = {W_DATA{1'b0}};
      din_ready_s    = 1'b0;
      cfg_ready_s    = 1'b0;
      hs_s           = 1'b0;
      if (rst) begin
         mode_d = PASS;
         cnt_d  = {W_CFG{1'b0}};
      end else begin
         case (mode_q)
            PASS: begin
               dout_valid_s   = din.valid & cfg.valid;
               din_ready_s    = cfg.valid & dout.ready;
               dout_eot_s     = din_eot_s & reach_s;
               dout_payload_s = din.data[W_DATA-1:0];
               hs_s           = dout_valid_s & dout.ready;
               if (hs_s) begin
                  if (din_eot_s && reach_s) begin
                     cfg_ready_s = 1'b1;
                     cnt_d       = {W_CFG{1'b0}};
                  end else if (din_eot_s) begin
                     cnt_d  = cnt_next_s[W_CFG-1:0];
                     mode_d = PAD;
                  end else if (cnt_next_s[W_CFG]) begin
                     cnt_d = cnt_q;
                  end else begin
                     cnt_d = cnt_next_s[W_CFG-1:0];
                  end
               end else begin
                  cnt_d = cnt_q;
               end
            end
            PAD: begin
               dout_valid_s   = cfg.valid;
               dout_eot_s     = exact_s;
               dout_payload_s = PAD_VAL;
               hs_s           = dout_valid_s & dout.ready;
               if (hs_s && exact_s) begin
                  cfg_ready_s = 1'b1;
                  cnt_d       = {W_CFG{1'b0}};
                  mode_d      = PASS;
               end else if (hs_s) begin
                  cnt_d = cnt_next_s[W_CFG-1:0];
               end else begin
                  cnt_d = cnt_q;
               end
            end
            default: begin
               mode_d = PASS;
               cnt_d  = {W_CFG{1'b0}};
            end
         endcase
      end
   end

   // State registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         mode_q <= PASS;
         cnt_q  <= {W_CFG{1'b0}};
      end else begin
         mode_q <= mode_d;
         cnt_q  <= cnt_d;
      end
   end

   assign dout.valid = dout_valid_s;
   assign dout.data  = {dout_eot_s, dout_payload_s};
   assign din.ready  = din_ready_s;
   assign cfg.ready  = cfg_ready_s;

endmodule
